// File: rtl/pc_stack_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_stack_unit
// Brief    : Program counter with return-address stack, signed relative
//            branch and fetch valid/ready handshake. Define PC_RAS_EN to
//            build the call/return stack; otherwise call/ret act as hold.
// Revision : 1.0 - initial release
// ============================================================================
module pc_stack_unit #(
   parameter int                ADDR_W      = 32,
   parameter int                STACK_DEPTH = 8,
   parameter int                STEP        = 1,
   parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [2:0]                   pc_op,
   input  logic [ADDR_W-1:0]            pc_set,
   output logic                         op_ready,
   output logic [ADDR_W-1:0]            pc_addr,
   output logic                         fetch_valid,
   input  logic                         fetch_ready,
   output logic [$clog2(STACK_DEPTH):0] stack_cnt,
   output logic                         stk_ovf,
   output logic                         stk_unf,
   input  logic                         err_clr
);

   localparam logic [2:0]        OP_INC = 3'b001;
   localparam logic [2:0]        OP_DEC = 3'b010;
   localparam logic [2:0]        OP_SET = 3'b011;
   localparam logic [2:0]        OP_ADD = 3'b100;
   localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);

   logic [ADDR_W-1:0] pc_nxt;
   logic              fv_nxt;
   logic              load;

   // Ready depends only on the handshake state, never on pc_op.
   assign op_ready = !fetch_valid || fetch_ready;

`ifdef PC_RAS_EN
   localparam logic [2:0] OP_CALL = 3'b101;
   localparam logic [2:0] OP_RET  = 3'b110;
   localparam int         CNT_W   = $clog2(STACK_DEPTH) + 1;
   localparam int         PTR_W   = $clog2(STACK_DEPTH);

   logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
   logic [PTR_W-1:0]  top_idx;
   logic [PTR_W-1:0]  push_idx;
   logic              stack_full;
   logic              stack_empty;
   logic              push;
   logic              pop;
   logic              ovf_hit;
   logic              unf_hit;

   assign stack_full  = (stack_cnt == CNT_W'(STACK_DEPTH));
   assign stack_empty = (stack_cnt == '0);
   assign top_idx     = PTR_W'(stack_cnt - CNT_W'(1));
   assign push_idx    = PTR_W'(stack_cnt);
`endif

   always_comb begin
      pc_nxt = pc_addr;
      load   = 1'b0;
`ifdef PC_RAS_EN
      push    = 1'b0;
      pop     = 1'b0;
      ovf_hit = 1'b0;
      unf_hit = 1'b0;
`endif
      if (op_ready) begin
         case (pc_op)
            OP_INC: begin
               pc_nxt = pc_addr + STEP_V;
               load   = 1'b1;
            end
            OP_DEC: begin
               pc_nxt = pc_addr - STEP_V;
               load   = 1'b1;
            end
            OP_SET: begin
               pc_nxt = pc_set;
               load   = 1'b1;
            end
            OP_ADD: begin
               pc_nxt = pc_addr + pc_set;
               load   = 1'b1;
            end
`ifdef PC_RAS_EN
            OP_CALL: begin
               if (stack_full) begin
                  ovf_hit = 1'b1;
               end else begin
                  push   = 1'b1;
                  pc_nxt = pc_set;
                  load   = 1'b1;
               end
            end
            OP_RET: begin
               if (stack_empty) begin
                  unf_hit = 1'b1;
               end else begin
                  pop    = 1'b1;
                  pc_nxt = stack_mem[top_idx];
                  load   = 1'b1;
               end
            end
`endif
            default: ;
         endcase
      end
      // A new address re-arms fetch; otherwise a taken fetch drops valid.
      fv_nxt = load || (fetch_valid && !fetch_ready);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_addr     <= RESET_ADDR;
         fetch_valid <= 1'b1;
      end else begin
         pc_addr     <= pc_nxt;
         fetch_valid <= fv_nxt;
      end
   end

`ifdef PC_RAS_EN
   always_ff @(posedge clk) begin
      if (push) begin
         stack_mem[push_idx] <= pc_addr + STEP_V;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stack_cnt <= '0;
         stk_ovf   <= 1'b0;
         stk_unf   <= 1'b0;
      end else begin
         if (push) begin
            stack_cnt <= stack_cnt + CNT_W'(1);
         end else if (pop) begin
            stack_cnt <= stack_cnt - CNT_W'(1);
         end
         // A fresh error in the clearing cycle keeps the flag set.
         stk_ovf <= ovf_hit || (stk_ovf && !err_clr);
         stk_unf <= unf_hit || (stk_unf && !err_clr);
      end
   end
`else
   logic unused_err_clr;

   assign unused_err_clr = err_clr;
   assign stack_cnt      = '0;
   assign stk_ovf        = 1'b0;
   assign stk_unf        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_stack_unit.sv
`default_nettype none
// Directed bench for pc_stack_unit: vector table for PC arithmetic and
// handshake, hand sequences for call/ret, overflow/underflow and async reset.
module tb_pc_stack_unit;

   localparam int          ADDR_W = 32;
   localparam int          DEPTH  = 8;
   localparam logic [31:0] RST_PC = 32'h100;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [2:0]        pc_op;
   logic [ADDR_W-1:0] pc_set;
   logic              op_ready;
   logic [ADDR_W-1:0] pc_addr;
   logic              fetch_valid;
   logic              fetch_ready;
   logic [3:0]        stack_cnt;
   logic              stk_ovf;
   logic              stk_unf;
   logic              err_clr;

   int compared   = 0;
   int mismatched = 0;

   pc_stack_unit #(
      .ADDR_W      (ADDR_W),
      .STACK_DEPTH (DEPTH),
      .STEP        (1),
      .RESET_ADDR  (RST_PC)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pc_op       (pc_op),
      .pc_set      (pc_set),
      .op_ready    (op_ready),
      .pc_addr     (pc_addr),
      .fetch_valid (fetch_valid),
      .fetch_ready (fetch_ready),
      .stack_cnt   (stack_cnt),
      .stk_ovf     (stk_ovf),
      .stk_unf     (stk_unf),
      .err_clr     (err_clr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] set;
      logic        fr;
      logic        rdy;
      logic [31:0] pc;
      logic        fv;
   } vec_t;

   vec_t vecs [18];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_state(input string tag, input logic [31:0] pc, input logic fv,
                            input logic [3:0] cnt, input logic ovf, input logic unf);
      chk({tag, ".pc"}, 64'(pc_addr), 64'(pc));
      chk({tag, ".fv"}, 64'(fetch_valid), 64'(fv));
      chk({tag, ".cnt"}, 64'(stack_cnt), 64'(cnt));
      chk({tag, ".ovf"}, 64'(stk_ovf), 64'(ovf));
      chk({tag, ".unf"}, 64'(stk_unf), 64'(unf));
   endtask

   task automatic do_op(input logic [2:0] op, input logic [31:0] set,
                        input logic fr, input logic clr);
      pc_op       = op;
      pc_set      = set;
      fetch_ready = fr;
      err_clr     = clr;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // op, set, fetch_ready, exp op_ready, exp pc, exp fetch_valid
      vecs[0]  = '{3'b001, 32'h0,        1'b1, 1'b1, 32'h101,      1'b1};
      vecs[1]  = '{3'b001, 32'h0,        1'b1, 1'b1, 32'h102,      1'b1};
      vecs[2]  = '{3'b001, 32'h0,        1'b1, 1'b1, 32'h103,      1'b1};
      vecs[3]  = '{3'b011, 32'h10,       1'b1, 1'b1, 32'h10,       1'b1};
      vecs[4]  = '{3'b100, 32'hFFFFFFFC, 1'b1, 1'b1, 32'h0C,       1'b1};
      vecs[5]  = '{3'b011, 32'hFFFFFFFF, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b1};
      vecs[6]  = '{3'b001, 32'h0,        1'b1, 1'b1, 32'h0,        1'b1};
      vecs[7]  = '{3'b010, 32'h0,        1'b1, 1'b1, 32'hFFFFFFFF, 1'b1};
      vecs[8]  = '{3'b000, 32'h55,       1'b1, 1'b1, 32'hFFFFFFFF, 1'b0};
      vecs[9]  = '{3'b111, 32'h55,       1'b0, 1'b1, 32'hFFFFFFFF, 1'b0};
      vecs[10] = '{3'b100, 32'h5,        1'b0, 1'b1, 32'h4,        1'b1};
      vecs[11] = '{3'b011, 32'h40,       1'b0, 1'b0, 32'h4,        1'b1};
      vecs[12] = '{3'b011, 32'h40,       1'b0, 1'b0, 32'h4,        1'b1};
      vecs[13] = '{3'b011, 32'h40,       1'b0, 1'b0, 32'h4,        1'b1};
      vecs[14] = '{3'b011, 32'h40,       1'b1, 1'b1, 32'h40,       1'b1};
      vecs[15] = '{3'b100, 32'h10,       1'b1, 1'b1, 32'h50,       1'b1};
      vecs[16] = '{3'b000, 32'h0,        1'b1, 1'b1, 32'h50,       1'b0};
      vecs[17] = '{3'b010, 32'h0,        1'b0, 1'b1, 32'h4F,       1'b1};

      rst_n       = 1'b0;
      pc_op       = 3'b000;
      pc_set      = '0;
      fetch_ready = 1'b0;
      err_clr     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_state("reset", RST_PC, 1'b1, 4'd0, 1'b0, 1'b0);
      chk("reset.rdy", 64'(op_ready), 64'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 18; i++) begin
         pc_op       = vecs[i].op;
         pc_set      = vecs[i].set;
         fetch_ready = vecs[i].fr;
         #1;
         chk($sformatf("vec%0d.rdy", i), 64'(op_ready), 64'(vecs[i].rdy));
         @(posedge clk);
         #1;
         chk_state($sformatf("vec%0d", i), vecs[i].pc, vecs[i].fv, 4'd0, 1'b0, 1'b0);
      end

`ifdef PC_RAS_EN
      do_op(3'b011, 32'h20, 1'b1, 1'b0);
      chk_state("set20", 32'h20, 1'b1, 4'd0, 1'b0, 1'b0);
      do_op(3'b101, 32'h80, 1'b1, 1'b0);
      chk_state("call80", 32'h80, 1'b1, 4'd1, 1'b0, 1'b0);
      do_op(3'b110, 32'h0, 1'b1, 1'b0);
      chk_state("ret1", 32'h21, 1'b1, 4'd0, 1'b0, 1'b0);
      do_op(3'b110, 32'h0, 1'b1, 1'b0);
      chk_state("ret_empty", 32'h21, 1'b0, 4'd0, 1'b0, 1'b1);
      do_op(3'b000, 32'h0, 1'b1, 1'b1);
      chk_state("clr_unf", 32'h21, 1'b0, 4'd0, 1'b0, 1'b0);
      do_op(3'b110, 32'h0, 1'b1, 1'b1);
      chk_state("unf_wins", 32'h21, 1'b0, 4'd0, 1'b0, 1'b1);
      do_op(3'b000, 32'h0, 1'b1, 1'b1);
      chk_state("clr_unf2", 32'h21, 1'b0, 4'd0, 1'b0, 1'b0);

      do_op(3'b011, 32'h200, 1'b1, 1'b0);
      for (int i = 0; i < DEPTH; i++) begin
         do_op(3'b101, 32'h1000 + 32'(i) * 32'h10, 1'b1, 1'b0);
         chk_state($sformatf("call%0d", i), 32'h1000 + 32'(i) * 32'h10, 1'b1,
                   4'(i + 1), 1'b0, 1'b0);
      end
      do_op(3'b101, 32'h1080, 1'b1, 1'b0);
      chk_state("call_full", 32'h1070, 1'b0, 4'd8, 1'b1, 1'b0);
      for (int k = 0; k < DEPTH; k++) begin
         logic [31:0] exp_ra;
         int          slot;
         slot   = DEPTH - 1 - k;
         exp_ra = (slot == 0) ? 32'h201 : 32'h1000 + 32'(slot - 1) * 32'h10 + 32'h1;
         do_op(3'b110, 32'h0, 1'b1, 1'b0);
         chk_state($sformatf("pop%0d", k), exp_ra, 1'b1, 4'(DEPTH - 1 - k), 1'b1, 1'b0);
      end
      do_op(3'b101, 32'h300, 1'b1, 1'b0);
      do_op(3'b101, 32'h310, 1'b1, 1'b0);
      chk_state("refill", 32'h310, 1'b1, 4'd2, 1'b1, 1'b0);
`else
      do_op(3'b101, 32'h80, 1'b1, 1'b1);
      chk_state("call_off", 32'h4F, 1'b0, 4'd0, 1'b0, 1'b0);
      do_op(3'b110, 32'h0, 1'b0, 1'b0);
      chk_state("ret_off", 32'h4F, 1'b0, 4'd0, 1'b0, 1'b0);
      do_op(3'b001, 32'h0, 1'b1, 1'b0);
      chk_state("inc_off", 32'h50, 1'b1, 4'd0, 1'b0, 1'b0);
`endif

      pc_op = 3'b000;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_state("async_rst", RST_PC, 1'b1, 4'd0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      do_op(3'b001, 32'h0, 1'b1, 1'b0);
      chk_state("post_rst", RST_PC + 32'h1, 1'b1, 4'd0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
